// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam int unsigned BIRTH_N    = 3;
  localparam int unsigned SURVIVE_LO = 2;
  localparam int unsigned SURVIVE_HI = 3;
  localparam int unsigned NCNT_W     = 4;

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation of one grid row from its three-row neighbourhood.
module life_row_next
  import life_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] row_above,
  input  logic [WIDTH-1:0] row_cur,
  input  logic [WIDTH-1:0] row_below,
  input  logic             wrap,
  output logic [WIDTH-1:0] row_next_c
);

  for (genvar x = 0; x < WIDTH; x++) begin : g_cell
    localparam int unsigned XL = (x == 0) ? WIDTH - 1 : x - 1;
    localparam int unsigned XR = (x == WIDTH - 1) ? 0 : x + 1;

    logic              has_l;
    logic              has_r;
    logic [NCNT_W-1:0] cnt;

    // Side columns only exist at the grid edge when wrapping
    assign has_l = wrap | (x != 0);
    assign has_r = wrap | (x != WIDTH - 1);

    assign cnt = NCNT_W'(row_above[x]) + NCNT_W'(row_below[x])
               + NCNT_W'(has_l & row_above[XL]) + NCNT_W'(has_l & row_cur[XL])
               + NCNT_W'(has_l & row_below[XL])
               + NCNT_W'(has_r & row_above[XR]) + NCNT_W'(has_r & row_cur[XR])
               + NCNT_W'(has_r & row_below[XR]);

    assign row_next_c[x] = row_cur[x]
      ? ((cnt >= NCNT_W'(SURVIVE_LO)) && (cnt <= NCNT_W'(SURVIVE_HI)))
      : (cnt == NCNT_W'(BIRTH_N));
  end

endmodule

// File: rtl/life_grid_engine.sv
// Row-serial Game of Life engine with shadow buffer and atomic commit.
// Optional registered live-cell count enabled by LIFE_GRID_POPCOUNT_EN.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic [WIDTH*HEIGHT-1:0]              load_val,
  input  logic                                 step,
  input  logic                                 run_enb,
  input  logic                                 tick,
  input  logic                                 wrap,
  output logic [WIDTH*HEIGHT-1:0]              alive,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 stable,
  output logic                                 overrun,
  output logic [GEN_W-1:0]                     generation,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    population
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned POP_W = $clog2(WIDTH * HEIGHT + 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       alive_q, alive_d;
  logic [N-1:0]       shadow_q, shadow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stable_q, stable_d;
  logic               overrun_q, overrun_d;
  logic [GEN_W-1:0]   gen_q, gen_d;

  logic               start_c;
  logic [WIDTH-1:0]   grid_rows [HEIGHT];
  logic [ROW_W-1:0]   idx_above_c, idx_below_c;
  logic [WIDTH-1:0]   row_above_c, row_cur_c, row_below_c, row_next_c;

  assign start_c = step | (run_enb & tick);

  for (genvar y = 0; y < HEIGHT; y++) begin : g_rows
    assign grid_rows[y] = alive_q[y*WIDTH +: WIDTH];
  end

  // Neighbour rows always come from the committed grid, never the shadow
  always_comb begin
    idx_above_c = (row_q == '0) ? ROW_W'(HEIGHT - 1) : row_q - ROW_W'(1);
    idx_below_c = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
    row_cur_c   = grid_rows[row_q];
    row_above_c = (wrap_q || (row_q != '0)) ? grid_rows[idx_above_c] : '0;
    row_below_c = (wrap_q || (row_q != ROW_W'(HEIGHT - 1))) ? grid_rows[idx_below_c] : '0;
  end

  life_row_next #(
    .WIDTH(WIDTH)
  ) u_row_next (
    .row_above  (row_above_c),
    .row_cur    (row_cur_c),
    .row_below  (row_below_c),
    .wrap       (wrap_q),
    .row_next_c (row_next_c)
  );

  // Next-state and output logic; load overrides every state
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wrap_d    = wrap_q;
    alive_d   = alive_q;
    shadow_d  = shadow_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    busy_d    = (state_q != IDLE);

    if (load) begin
      state_d  = IDLE;
      row_d    = '0;
      alive_d  = load_val;
      shadow_d = '0;
      gen_d    = '0;
      stable_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_d = COMPUTE;
            wrap_d  = wrap;
            row_d   = '0;
          end
        end
        COMPUTE: begin
          overrun_d = start_c;
          for (int unsigned y = 0; y < HEIGHT; y++) begin
            if (row_q == ROW_W'(y)) shadow_d[y*WIDTH +: WIDTH] = row_next_c;
          end
          if (row_q == ROW_W'(HEIGHT - 1)) state_d = COMMIT;
          else                             row_d   = row_q + ROW_W'(1);
        end
        COMMIT: begin
          overrun_d = start_c;
          alive_d   = shadow_q;
          stable_d  = (shadow_q == alive_q);
          gen_d     = gen_q + GEN_W'(1);
          done_d    = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      wrap_q    <= 1'b0;
      alive_q   <= '0;
      shadow_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stable_q  <= 1'b0;
      overrun_q <= 1'b0;
      gen_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wrap_q    <= wrap_d;
      alive_q   <= alive_d;
      shadow_q  <= shadow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stable_q  <= stable_d;
      overrun_q <= overrun_d;
      gen_q     <= gen_d;
    end
  end

`ifdef LIFE_GRID_POPCOUNT_EN
  logic [POP_W-1:0] pop_q, pop_d;

  // alive_d only differs from alive_q on load or commit
  always_comb begin
    pop_d = '0;
    for (int unsigned i = 0; i < N; i++) pop_d = pop_d + POP_W'(alive_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pop_q <= '0;
    else        pop_q <= pop_d;
  end

  assign population = pop_q;
`else
  assign population = POP_W'(0);
`endif

  assign alive      = alive_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stable     = stable_q;
  assign overrun    = overrun_q;
  assign generation = gen_q;

endmodule

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Game of Life generation engine that replaces the fixed 4x4 cell array behind the display tiles. Holds a WIDTH x HEIGHT grid in registers and computes the next generation row-serially, one row per cycle, into a shadow buffer that commits atomically. Provides preset load, single-step, tick-driven run mode, and selectable dead or toroidal edges. Reports generation count and stability status to the top level and the VGA display path.

## Interface
- WIDTH, 8: grid columns, 3..64
- HEIGHT, 8: grid rows, 3..64
- GEN_W, 16: generation counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- load  in  1  pulse: copy load_val into the grid
- load_val  in  WIDTH*HEIGHT  preset; cell (x,y) at bit y*WIDTH+x
- step  in  1  pulse: compute one generation
- run_enb  in  1  level: tick starts a generation
- tick  in  1  one-cycle pulse from the timer
- wrap  in  1  1 = toroidal edges, 0 = cells outside grid are dead; sampled when a generation starts
- alive  out  WIDTH*HEIGHT  committed grid, same bit mapping
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse on commit
- stable  out  1  last committed generation equalled its predecessor
- overrun  out  1  one-cycle pulse when a start request is dropped because busy
- generation  out  GEN_W  committed generations since last load or reset
- population  out  clog2(WIDTH*HEIGHT+1)  live-cell count (see Configuration)

## Operation
- Reset: alive=0, busy=0, done=0, stable=0, overrun=0, generation=0, population=0, state IDLE.
- Start request = step | (run_enb & tick).
- States:
  - IDLE: on a start request, latch wrap, set row=0, and go to COMPUTE.
  - COMPUTE: write next-row(row) into the shadow buffer. Increment row. After row HEIGHT-1, go to COMMIT.
  - COMMIT: alive <= shadow; stable <= (shadow == alive); generation += 1 (wraps mod 2^GEN_W); done=1; return to IDLE.
- Rules: count the 8 neighbours (4-bit sum). A live cell survives with 2 or 3 neighbours. A dead cell is born with exactly 3. All others are dead.
- Edges:
  - wrap=1: row and column indices taken mod HEIGHT/WIDTH.
  - wrap=0: out-of-range neighbours count 0.
- COMPUTE reads only the committed alive grid. It never reads the partially written shadow buffer.
- Load has priority over everything:
  - In any state, load sets alive=load_val, generation=0, stable=0, clears the shadow buffer, and forces IDLE.
  - A start request in the same cycle as load is ignored.
- Start request while busy: dropped, overrun=1 for that cycle.
- run_enb=0: tick ignored with no overrun. step still works.

## Timing
- Start request accepted at edge t → busy=1 from t+1 through t+HEIGHT+1.
- alive, generation, stable, done change at edge t+HEIGHT+1. busy=0 after edge t+HEIGHT+2.
- Back-to-back: the earliest next accept is the cycle after COMMIT (IDLE cycle). Throughput is one generation per HEIGHT+2 cycles.
- Load takes effect at the next edge. busy=0 the cycle after load.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LIFE_GRID_POPCOUNT_EN defined: population is registered. It is updated at COMMIT and at load with the popcount of the new grid.
- LIFE_GRID_POPCOUNT_EN undefined: population is tied to 0 and no adder tree is built.

## Structure
- Package life_pkg holds:
  - state enum (IDLE, COMPUTE, COMMIT)
  - rule constants: BIRTH_N=3, SURVIVE_LO=2, SURVIVE_HI=3
  - neighbour-count width constant (4)
- Sub-module life_row_next: combinational; takes the above, current, and below rows plus wrap, and returns the WIDTH-bit next row. It is instantiated once, with the FSM supplying the rows.

## Test plan
Use WIDTH=4, HEIGHT=4.
- Reset, then load 16'h0700, wrap=0, step → after 5 cycles alive=16'h2220, generation=1, done pulse, stable=0. Step again → 16'h0700, generation=2.
- Load 16'h0660, step → alive=16'h0660, stable=1. Load 16'h3300, step → alive=16'h3300, stable=1.
- Load 16'h0007, step with wrap=0 → 16'h0022. Reload, step with wrap=1 → 16'h2022.
- run_enb=1, tick pulsed every 3 cycles → every second tick raises overrun, one generation per 6 cycles, no lost commits.
- Assert load 16'h0660 mid-COMPUTE → next cycle alive=16'h0660, busy=0, generation=0, no done pulse.
- Assert reset mid-COMPUTE → all outputs 0 immediately. With LIFE_GRID_POPCOUNT_EN defined, load 16'h33CC → population=8.
